// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier, DATA_W x DATA_W -> hi:lo, with start/busy/done handshake.
// Optional unsigned mode when BOOTH_MULT_UNSIGNED_EN is defined (adds port mult_unsigned).
module booth_mult #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
`ifdef BOOTH_MULT_UNSIGNED_EN
    input  logic              mult_unsigned,
`endif
    input  logic [DATA_W-1:0] mult_a,
    input  logic [DATA_W-1:0] mult_b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy,
    output logic              done
);

`ifdef BOOTH_MULT_UNSIGNED_EN
    localparam int EXT = 1;
`else
    localparam int EXT = 0;
`endif
    // Unsigned mode needs one extra operand bit and one extra guard bit in A.
    localparam int AW = DATA_W + 1 + EXT;
    localparam int QW = DATA_W + EXT;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]        state;
    logic [AW-1:0]     a_r, m_r, sum, a_nx;
    logic [QW-1:0]     q_r, q_nx;
    logic              q_m1;
    logic [CNT_W-1:0]  cnt, last_cnt;
    logic              uns_in;
    logic [DATA_W+1:0] a_x;
    logic [DATA_W:0]   b_x;
    logic [2*DATA_W-1:0] prod;

`ifdef BOOTH_MULT_UNSIGNED_EN
    logic uns_r;
    assign uns_in   = mult_unsigned;
    assign last_cnt = uns_r ? CNT_W'(DATA_W) : CNT_W'(DATA_W - 1);
`else
    assign uns_in   = 1'b0;
    assign last_cnt = CNT_W'(DATA_W - 1);
`endif

    assign a_x  = {{2{~uns_in & mult_a[DATA_W-1]}}, mult_a};
    assign b_x  = {~uns_in & mult_b[DATA_W-1], mult_b};
    assign busy = (state == RUN);

    always_comb begin
        case ({q_r[0], q_m1})
            2'b01:   sum = a_r + m_r;
            2'b10:   sum = a_r - m_r;
            default: sum = a_r;
        endcase
        a_nx = {sum[AW-1], sum[AW-1:1]};
        q_nx = {sum[0], q_r[QW-1:1]};
    end

    // Signed runs stop one step short in the wide build, leaving the product one bit up.
    always_comb begin
`ifdef BOOTH_MULT_UNSIGNED_EN
        if (uns_r)
            prod = {a_nx[DATA_W-2:0], q_nx};
        else
            prod = {a_nx[DATA_W-1:0], q_nx[DATA_W:1]};
`else
        prod = {a_nx[DATA_W-1:0], q_nx};
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            a_r   <= '0;
            m_r   <= '0;
            q_r   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
`ifdef BOOTH_MULT_UNSIGNED_EN
            uns_r <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m_r   <= a_x[AW-1:0];
                        q_r   <= b_x[QW-1:0];
                        q_m1  <= 1'b0;
                        a_r   <= '0;
                        cnt   <= '0;
                        state <= RUN;
`ifdef BOOTH_MULT_UNSIGNED_EN
                        uns_r <= uns_in;
`endif
                    end
                end
                default: begin
                    a_r  <= a_nx;
                    q_r  <= q_nx;
                    q_m1 <= q_r[0];
                    cnt  <= cnt + 1'b1;
                    if (cnt == last_cnt) begin
                        hi    <= prod[2*DATA_W-1:DATA_W];
                        lo    <= prod[DATA_W-1:0];
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult.sv
// Scoreboard bench for booth_mult: stimulus pushes expected results, a monitor pops them on done.
module tb_booth_mult;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] mult_a, mult_b;
    logic [31:0] hi, lo;
    logic        busy, done;
`ifdef BOOTH_MULT_UNSIGNED_EN
    logic        mult_unsigned = 1'b0;
`endif

    booth_mult #(.DATA_W(32), .CNT_W(6)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
`ifdef BOOTH_MULT_UNSIGNED_EN
        .mult_unsigned(mult_unsigned),
`endif
        .mult_a(mult_a),
        .mult_b(mult_b),
        .hi(hi),
        .lo(lo),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          done_cyc;
        int          steps;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] last_hi = '0, last_lo = '0;
    int          busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse and checks hold behaviour while busy.
    always @(negedge clk) begin
        if (reset) begin
            last_hi  = '0;
            last_lo  = '0;
            busy_cnt = 0;
        end else if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("hi", 64'(hi), 64'(e.hi));
                chk("lo", 64'(lo), 64'(e.lo));
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                chk("busy_cycles", 64'(busy_cnt), 64'(e.steps));
                chk("busy_in_done", 64'(busy), 64'd0);
            end
            last_hi  = hi;
            last_lo  = lo;
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
            chk("hold_hilo", {hi, lo}, {last_hi, last_lo});
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic uns,
                         input logic [31:0] eh, input logic [31:0] el, input int steps);
        exp_t e;
        mult_a = a;
        mult_b = b;
`ifdef BOOTH_MULT_UNSIGNED_EN
        mult_unsigned = uns;
`else
        if (uns) $display("note: unsigned request ignored in signed-only build");
`endif
        start = 1'b1;
        e.hi = eh; e.lo = el; e.done_cyc = cyc + 1 + steps; e.steps = steps;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("timeout", 64'd1, 64'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        exp_t e;
        reset = 1'b1; start = 1'b0; mult_a = '0; mult_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(32'd7, 32'd6, 1'b0, 32'h0, 32'h2A, 32);
        wait_idle();
        issue(32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32);
        wait_idle();
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0, 32);
        wait_idle();

        // start while busy must be ignored, operand changes must not matter
        issue(32'd12, 32'd12, 1'b0, 32'h0, 32'h90, 32);
        repeat (3) @(negedge clk);
        mult_a = 32'hFFFF_FFFF; mult_b = 32'd2; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            mult_a = ~mult_a; mult_b = mult_b + 32'd3;
        end
        start = 1'b0;
        wait_idle();

        // back-to-back: start held into the done cycle
        mult_a = 32'd5; mult_b = 32'd5; start = 1'b1;
        c = cyc;
        e.hi = 32'h0; e.lo = 32'd25; e.done_cyc = c + 33; e.steps = 32;
        sb.push_back(e);
        for (int i = 0; i < 40 && cyc < c + 33; i++) @(negedge clk);
        chk("b2b_done_seen", 64'(done), 64'd1);
        mult_a = 32'h0001_0000; mult_b = 32'h0001_0000;
        e.hi = 32'h1; e.lo = 32'h0; e.done_cyc = cyc + 33; e.steps = 32;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset mid-operation aborts with no done pulse
        mult_a = 32'd9; mult_b = 32'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        issue(32'd3, 32'd4, 1'b0, 32'h0, 32'h0C, 32);
        wait_idle();

`ifdef BOOTH_MULT_UNSIGNED_EN
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h1, 33);
        wait_idle();
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h1, 32);
        wait_idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
